// File: rtl/count_pkg.sv
// Shared opcode and state encodings for the counter sequencer.
package count_pkg;

    localparam logic [1:0] OP_RUN_UP   = 2'd0;
    localparam logic [1:0] OP_RUN_DOWN = 2'd1;
    localparam logic [1:0] OP_PINGPONG = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UP     = 2'd1,
        ST_DOWN   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

endpackage

// File: rtl/updown_count_core.sv
// Loadable up/down counter datapath; load has priority over enable.
module updown_count_core #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= up ? count + WIDTH'(1) : count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/count_seq_ctrl.sv
// Command-driven sequencer stepping an up/down counter through up, down or ping-pong runs.
//  state     | meaning
//  ST_IDLE   | waiting for a command, cmd_ready high
//  ST_UP     | incrementing toward the held limit
//  ST_DOWN   | decrementing toward zero
//  ST_FINISH | single run complete, one-cycle done pulse
module count_seq_ctrl
    import count_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             dir,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             pingpong_q, pingpong_d;
    logic             dir_q, dir_d;
    logic             load, en, up;
    logic [WIDTH-1:0] load_val;

    updown_count_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .up       (up),
        .count    (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            limit_q    <= '0;
            pingpong_q <= 1'b0;
            dir_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            limit_q    <= limit_d;
            pingpong_q <= pingpong_d;
            dir_q      <= dir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        limit_d    = limit_q;
        pingpong_d = pingpong_q;
        dir_d      = dir_q;
        load       = 1'b0;
        load_val   = '0;
        en         = 1'b0;
        up         = 1'b1;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_RUN_UP, OP_PINGPONG: begin
                            load       = 1'b1;
                            load_val   = '0;
                            limit_d    = cmd_limit;
                            dir_d      = 1'b1;
                            pingpong_d = (cmd_op == OP_PINGPONG);
                            state_d    = ST_UP;
                        end
                        OP_RUN_DOWN: begin
                            load       = 1'b1;
                            load_val   = cmd_limit;
                            limit_d    = cmd_limit;
                            dir_d      = 1'b0;
                            pingpong_d = 1'b0;
                            state_d    = ST_DOWN;
                        end
                        default: ;
                    endcase
                end
            end
            ST_UP: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    // Terminal compare precedes the step, so the counter never wraps.
                    if (count == limit_q) begin
                        if (pingpong_q) begin
                            state_d = ST_DOWN;
                            dir_d   = 1'b0;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end else begin
                        en = 1'b1;
                        up = 1'b1;
                    end
                end
            end
            ST_DOWN: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (!pause) begin
                    if (count == '0) begin
                        if (pingpong_q) begin
                            state_d = ST_UP;
                            dir_d   = 1'b1;
                        end else begin
                            state_d = ST_FINISH;
                        end
                    end else begin
                        en = 1'b1;
                        up = 1'b0;
                    end
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q == ST_UP) || (state_q == ST_DOWN);
    assign done      = (state_q == ST_FINISH);
    assign dir       = dir_q;

endmodule
